uart_rx_deframer: RTL and testbench

- Serial-to-parallel UART receiver (8N1) that feeds the project core with bytes taken from one dedicated input pin.
- Sits between the top-level pin wrapper and the core logic.
- The wrapper drives `rx_i` from a `ui_in` bit and drives `rst` from the inverted `rst_n`.
- Output is a byte stream with a valid/ready handshake, one holding register, and sticky error reporting.

---
 rtl/uart_rx_deframer.sv | 110 +++++++++++
 tb/tb_uart_rx_deframer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronizes rx_i, samples each bit mid-period and
// presents bytes through a one-entry valid/ready holding register.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          s1, rxs, rxp;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      rxs       <= 1'b1;
      rxp       <= 1'b1;
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      s1        <= rx_i;
      rxs       <= s1;
      rxp       <= rxs;
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          // rxp stays low on a held-low line, so a break cannot retrigger
          if (rxp && !rxs) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
              bitn  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt  <= '0;
            sh   <= {rxs, sh[7:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rxs) begin
              // a same-cycle consume frees the register for the new byte
              if (!rx_valid || rx_ready) begin
                rx_data  <= sh;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at 8 clocks per bit.
module tb_uart_rx_deframer;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int busy_cnt = 0;
  int ov_cnt = 0;

  uart_rx_deframer #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frame_err === 1'b1) fe_cnt++;
    if (!rst && busy === 1'b1) busy_cnt++;
    if (!rst && overrun === 1'b1) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; optionally raise rx_ready
  // exactly on the cycle the stop bit is sampled.
  task automatic send(input logic [7:0] d, input logic stop, input logic rdy_at_load);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_i = fr[b];
      for (int c = 0; c < C; c++) begin
        if (rdy_at_load && b == 9) rx_ready = (c == 6);
        tick(1);
      end
    end
    if (rdy_at_load) rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    int b0;
    rst = 1'b1; rx_i = 1'b0;
    tick(2);
    rst = 1'b0; rx_i = 1'b1;
    if (rx_data !== 8'h00) begin $display("FAIL reset_data got=%h want=00", rx_data); bad++; end
    total++;
    if (rx_valid !== 1'b0) begin $display("FAIL reset_valid got=%b want=0", rx_valid); bad++; end
    total++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_ferr got=%b want=0", frame_err); bad++; end
    total++;
    if (overrun !== 1'b0) begin $display("FAIL reset_ovr got=%b want=0", overrun); bad++; end
    total++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); bad++; end
    total++;
    b0 = busy_cnt;
    tick(20);
    if (busy_cnt !== b0) begin $display("FAIL reset_no_frame busy_cycles=%0d want=0", busy_cnt - b0); bad++; end
    total++;
  endtask

  task automatic test_single;
    int held, f0, o0;
    f0 = fe_cnt; o0 = ov_cnt;
    send(8'hA5, 1'b1, 1'b0);
    if (rx_data !== 8'hA5) begin $display("FAIL a5_data got=%h want=a5", rx_data); bad++; end
    total++;
    held = 0;
    for (int i = 0; i < 50; i++) begin
      if (rx_valid === 1'b1 && rx_data === 8'hA5) held++;
      tick(1);
    end
    if (held !== 50) begin $display("FAIL a5_hold got=%0d want=50", held); bad++; end
    total++;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    if (rx_valid !== 1'b0) begin $display("FAIL a5_consume got=%b want=0", rx_valid); bad++; end
    total++;
    tick(3);
    if (fe_cnt !== f0) begin $display("FAIL a5_ferr cycles=%0d want=0", fe_cnt - f0); bad++; end
    total++;
    if (ov_cnt !== o0) begin $display("FAIL a5_ovr cycles=%0d want=0", ov_cnt - o0); bad++; end
    total++;
  endtask

  task automatic test_back_to_back;
    send(8'h3C, 1'b1, 1'b0);
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      $display("FAIL b2b_first got=%b/%h want=1/3c", rx_valid, rx_data); bad++;
    end
    total++;
    send(8'hC3, 1'b1, 1'b0);
    if (rx_data !== 8'h3C) begin $display("FAIL b2b_drop_data got=%h want=3c", rx_data); bad++; end
    total++;
    if (rx_valid !== 1'b1) begin $display("FAIL b2b_valid got=%b want=1", rx_valid); bad++; end
    total++;
    if (overrun !== 1'b1) begin $display("FAIL b2b_ovr got=%b want=1", overrun); bad++; end
    total++;
    tick(8);
    send(8'h5A, 1'b1, 1'b1);
    if (rx_data !== 8'h5A) begin $display("FAIL swap_data got=%h want=5a", rx_data); bad++; end
    total++;
    if (rx_valid !== 1'b1) begin $display("FAIL swap_valid got=%b want=1", rx_valid); bad++; end
    total++;
    if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got=%b want=1", overrun); bad++; end
    total++;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(8);
  endtask

  task automatic test_frame_error;
    int f0, b0;
    f0 = fe_cnt;
    send(8'hFF, 1'b0, 1'b0);
    if (fe_cnt - f0 !== 1) begin $display("FAIL ferr_pulse cycles=%0d want=1", fe_cnt - f0); bad++; end
    total++;
    if (rx_valid !== 1'b0) begin $display("FAIL ferr_valid got=%b want=0", rx_valid); bad++; end
    total++;
    tick(1);
    b0 = busy_cnt;
    tick(20 * C);
    if (busy_cnt !== b0) begin $display("FAIL break_busy cycles=%0d want=0", busy_cnt - b0); bad++; end
    total++;
    rx_i = 1'b1;
    tick(2 * C);
    send(8'h55, 1'b1, 1'b0);
    if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
      $display("FAIL after_break got=%b/%h want=1/55", rx_valid, rx_data); bad++;
    end
    total++;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(8);
  endtask

  task automatic test_glitch;
    int b0, f0;
    b0 = busy_cnt; f0 = fe_cnt;
    rx_i = 1'b0;
    tick(2);
    rx_i = 1'b1;
    tick(20);
    if (busy_cnt - b0 < 1 || busy_cnt - b0 > C) begin
      $display("FAIL glitch_busy cycles=%0d want=1..%0d", busy_cnt - b0, C); bad++;
    end
    total++;
    if (busy !== 1'b0) begin $display("FAIL glitch_idle got=%b want=0", busy); bad++; end
    total++;
    if (rx_valid !== 1'b0) begin $display("FAIL glitch_valid got=%b want=0", rx_valid); bad++; end
    total++;
    if (fe_cnt !== f0) begin $display("FAIL glitch_ferr cycles=%0d want=0", fe_cnt - f0); bad++; end
    total++;
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] part;
    part = 7'b0000_000;
    // start bit, data bits 0..2, then half of bit 3 (all low)
    for (int i = 0; i < 4 * C + C / 2; i++) begin
      rx_i = part[0];
      tick(1);
    end
    if (busy !== 1'b1) begin $display("FAIL midrst_pre_busy got=%b want=1", busy); bad++; end
    total++;
    rst = 1'b1; rx_i = 1'b1;
    tick(1);
    rst = 1'b0;
    if (busy !== 1'b0) begin $display("FAIL midrst_busy got=%b want=0", busy); bad++; end
    total++;
    tick(2 * C);
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL midrst_quiet got=%b/%b want=0/0", rx_valid, busy); bad++;
    end
    total++;
    send(8'h81, 1'b1, 1'b0);
    if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
      $display("FAIL midrst_next got=%b/%h want=1/81", rx_valid, rx_data); bad++;
    end
    total++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_frame_error;
    test_glitch;
    test_reset_mid_frame;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
